sync_fifo_param: RTL

Parametrised single-clock FIFO that replaces the fixed 8-bit × 256 vendor FIFO in the FIFO demo path. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, a selectable normal or show-ahead read mode, and sticky overflow/underflow error flags. It sits between a producer (the FIFO write sequencer) and a consumer (the FIFO read sequencer), both in the `sys_clk` domain.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ram.sv | 20 ++
 rtl/sync_fifo_param.sv | 71 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers and read-mode constants for the FIFO and its sequencers
package fifo_pkg;
    localparam int FIFO_NORMAL    = 0;
    localparam int FIFO_SHOWAHEAD = 1;
    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) ;
        return r;
    endfunction
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W simple dual-port array, registered write, asynchronous read
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with programmable thresholds, optional show-ahead
// read and sticky overflow/underflow flags
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 256,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4,
    parameter int SHOW_AHEAD = FIFO_NORMAL
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   usedw,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] AF_LVL   = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_LVL   = AE_LEVEL[AW:0];
    logic [AW:0]       wr_ptr, rd_ptr, lvl_nxt;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_q, rd_q;
    assign wr_acc  = wr_en & ~full;
    assign rd_acc  = rd_en & ~empty;
    assign lvl_nxt = usedw + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
    fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (sys_clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );
    // flags are registered from the next level so they move on the same edge as usedw
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            rd_q         <= '0;
        end else begin
            wr_ptr       <= wr_ptr + {{AW{1'b0}}, wr_acc};
            rd_ptr       <= rd_ptr + {{AW{1'b0}}, rd_acc};
            usedw        <= lvl_nxt;
            full         <= lvl_nxt == FULL_LVL;
            empty        <= lvl_nxt == '0;
            almost_full  <= lvl_nxt >= AF_LVL;
            almost_empty <= lvl_nxt <= AE_LVL;
            overflow     <= (wr_en & full) | (overflow & ~clr_err);
            underflow    <= (rd_en & empty) | (underflow & ~clr_err);
            rd_q         <= rd_acc ? ram_q : rd_q;
        end
    assign rd_data = (SHOW_AHEAD == FIFO_SHOWAHEAD) ? ram_q : rd_q;
endmodule
